axi3_burst_slave_mem: RTL and testbench

//  AXI3 slave (responder) backed by an internal word RAM; the far end of the AXI3 burst

---
 rtl/axi3_burst_slave_mem_if.sv | 63 ++++++
 rtl/axi3_burst_slave_mem.sv | 232 +++++++++++++++++++++++
 tb/tb_axi3_burst_slave_mem.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi3_burst_slave_mem_if.sv
// AXI3 write/read channel bundle between a burst master and the RAM-backed slave.
interface axi3_burst_slave_mem_if;
  logic [5:0]  AXI_awid;
  logic [31:0] AXI_awaddr;
  logic [3:0]  AXI_awlen;
  logic [2:0]  AXI_awsize;
  logic [1:0]  AXI_awburst;
  logic        AXI_awvalid;
  logic        AXI_awready;

  logic [5:0]  AXI_wid;
  logic [31:0] AXI_wdata;
  logic [3:0]  AXI_wstrb;
  logic        AXI_wlast;
  logic        AXI_wvalid;
  logic        AXI_wready;

  logic [5:0]  AXI_bid;
  logic [1:0]  AXI_bresp;
  logic        AXI_bvalid;
  logic        AXI_bready;

  logic [5:0]  AXI_arid;
  logic [31:0] AXI_araddr;
  logic [3:0]  AXI_arlen;
  logic [2:0]  AXI_arsize;
  logic [1:0]  AXI_arburst;
  logic        AXI_arvalid;
  logic        AXI_arready;

  logic [5:0]  AXI_rid;
  logic [31:0] AXI_rdata;
  logic [1:0]  AXI_rresp;
  logic        AXI_rlast;
  logic        AXI_rvalid;
  logic        AXI_rready;

  modport slave (
    input  AXI_awid, AXI_awaddr, AXI_awlen, AXI_awsize, AXI_awburst, AXI_awvalid,
    output AXI_awready,
    input  AXI_wid, AXI_wdata, AXI_wstrb, AXI_wlast, AXI_wvalid,
    output AXI_wready,
    output AXI_bid, AXI_bresp, AXI_bvalid,
    input  AXI_bready,
    input  AXI_arid, AXI_araddr, AXI_arlen, AXI_arsize, AXI_arburst, AXI_arvalid,
    output AXI_arready,
    output AXI_rid, AXI_rdata, AXI_rresp, AXI_rlast, AXI_rvalid,
    input  AXI_rready
  );

  modport master (
    output AXI_awid, AXI_awaddr, AXI_awlen, AXI_awsize, AXI_awburst, AXI_awvalid,
    input  AXI_awready,
    output AXI_wid, AXI_wdata, AXI_wstrb, AXI_wlast, AXI_wvalid,
    input  AXI_wready,
    input  AXI_bid, AXI_bresp, AXI_bvalid,
    output AXI_bready,
    output AXI_arid, AXI_araddr, AXI_arlen, AXI_arsize, AXI_arburst, AXI_arvalid,
    input  AXI_arready,
    input  AXI_rid, AXI_rdata, AXI_rresp, AXI_rlast, AXI_rvalid,
    output AXI_rready
  );
endinterface

// File: rtl/axi3_burst_slave_mem.sv
// AXI3 slave backed by a 2**ADDR_BITS x 32 word RAM. Independent write and read
// channels, one outstanding INCR burst per direction, 32-bit beats only.
//
// Write FSM
//   state  | meaning
//   W_IDLE | awready high, waiting for a write address
//   W_DATA | wready high, accepting beats 0..len
//   W_RESP | bvalid high, holding the write response
// Read FSM
//   state  | meaning
//   R_IDLE | arready high, waiting for a read address
//   R_DATA | rvalid high, presenting registered beat data
module axi3_burst_slave_mem #(
  parameter int ADDR_BITS = 10
) (
  input  logic                    AXI_clk,
  input  logic                    rst,
  axi3_burst_slave_mem_if.slave   axi,
  output logic [31:0]             wr_bcnt,
  output logic [31:0]             rd_bcnt
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

  logic [31:0] mem_q [DEPTH];

  wstate_e                wstate_q, wstate_d;
  logic [5:0]             wid_q, wid_d;
  logic [ADDR_BITS-1:0]   widx_q, widx_d;
  logic [3:0]             wlen_q, wlen_d;
  logic [3:0]             wbeat_q, wbeat_d;
  logic                   werr_q, werr_d;
  logic [31:0]            wr_bcnt_q, wr_bcnt_d;
  logic                   mem_we;
  logic                   awready, wready, bvalid;

  rstate_e                rstate_q, rstate_d;
  logic [5:0]             rid_q, rid_d;
  logic [ADDR_BITS-1:0]   ridx_q, ridx_d;
  logic [ADDR_BITS-1:0]   rnext_idx;
  logic [ADDR_BITS-1:0]   ar_idx;
  logic [3:0]             rlen_q, rlen_d;
  logic [3:0]             rbeat_q, rbeat_d;
  logic                   rerr_q, rerr_d;
  logic                   ar_err;
  logic [31:0]            rdata_q, rdata_d;
  logic                   rlast_q, rlast_d;
  logic [31:0]            rd_bcnt_q, rd_bcnt_d;
  logic                   arready, rvalid;

  // Address bits outside the word index and the write ID are deliberately ignored.
  logic unused_bits;
  assign unused_bits = ^{axi.AXI_wid,
                         axi.AXI_awaddr[31:ADDR_BITS+2], axi.AXI_awaddr[1:0],
                         axi.AXI_araddr[31:ADDR_BITS+2], axi.AXI_araddr[1:0]};

  // Write channel: next-state, handshake outputs and RAM write enable.
  always_comb begin
    wstate_d  = wstate_q;
    wid_d     = wid_q;
    widx_d    = widx_q;
    wlen_d    = wlen_q;
    wbeat_d   = wbeat_q;
    werr_d    = werr_q;
    wr_bcnt_d = wr_bcnt_q;
    mem_we    = 1'b0;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        awready = 1'b1;
        if (axi.AXI_awvalid) begin
          wid_d     = axi.AXI_awid;
          widx_d    = axi.AXI_awaddr[ADDR_BITS+1:2];
          wlen_d    = axi.AXI_awlen;
          wbeat_d   = 4'd0;
          werr_d    = (axi.AXI_awsize != 3'b010) | (axi.AXI_awburst != 2'b01);
          wstate_d  = W_DATA;
        end
      end
      W_DATA: begin
        wready = 1'b1;
        if (axi.AXI_wvalid) begin
          // Error from earlier beats suppresses this write; a misplaced wlast only
          // affects the beats that follow it.
          mem_we  = !werr_q;
          widx_d  = widx_q + 1'b1;
          wbeat_d = wbeat_q + 4'd1;
          if (wbeat_q == wlen_q) begin
            werr_d   = werr_q | !axi.AXI_wlast;
            wstate_d = W_RESP;
          end else begin
            werr_d   = werr_q | axi.AXI_wlast;
          end
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (axi.AXI_bready) begin
          wr_bcnt_d = wr_bcnt_q + 32'd1;
          wstate_d  = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Write channel state register.
  always_ff @(posedge AXI_clk) begin
    if (rst) begin
      wstate_q  <= W_IDLE;
      wid_q     <= '0;
      widx_q    <= '0;
      wlen_q    <= '0;
      wbeat_q   <= '0;
      werr_q    <= 1'b0;
      wr_bcnt_q <= '0;
    end else begin
      wstate_q  <= wstate_d;
      wid_q     <= wid_d;
      widx_q    <= widx_d;
      wlen_q    <= wlen_d;
      wbeat_q   <= wbeat_d;
      werr_q    <= werr_d;
      wr_bcnt_q <= wr_bcnt_d;
    end
  end

  // RAM byte-lane write; contents survive reset, but a beat on the reset edge is dropped.
  always_ff @(posedge AXI_clk) begin
    if (mem_we && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (axi.AXI_wstrb[i]) mem_q[widx_q][8*i +: 8] <= axi.AXI_wdata[8*i +: 8];
      end
    end
  end

  assign ar_idx    = axi.AXI_araddr[ADDR_BITS+1:2];
  assign ar_err    = (axi.AXI_arsize != 3'b010) | (axi.AXI_arburst != 2'b01);
  assign rnext_idx = ridx_q + 1'b1;

  // Read channel: next-state and beat loading. RAM is read before this edge's
  // write lands, so a same-cycle read of a written word sees the old value.
  always_comb begin
    rstate_d  = rstate_q;
    rid_d     = rid_q;
    ridx_d    = ridx_q;
    rlen_d    = rlen_q;
    rbeat_d   = rbeat_q;
    rerr_d    = rerr_q;
    rdata_d   = rdata_q;
    rlast_d   = rlast_q;
    rd_bcnt_d = rd_bcnt_q;
    arready   = 1'b0;
    rvalid    = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        arready = 1'b1;
        if (axi.AXI_arvalid) begin
          rid_d    = axi.AXI_arid;
          ridx_d   = ar_idx;
          rlen_d   = axi.AXI_arlen;
          rbeat_d  = 4'd0;
          rerr_d   = ar_err;
          rdata_d  = ar_err ? 32'd0 : mem_q[ar_idx];
          rlast_d  = (axi.AXI_arlen == 4'd0);
          rstate_d = R_DATA;
        end
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (axi.AXI_rready) begin
          if (rlast_q) begin
            rlast_d   = 1'b0;
            rd_bcnt_d = rd_bcnt_q + 32'd1;
            rstate_d  = R_IDLE;
          end else begin
            ridx_d  = rnext_idx;
            rbeat_d = rbeat_q + 4'd1;
            rdata_d = rerr_q ? 32'd0 : mem_q[rnext_idx];
            rlast_d = ((rbeat_q + 4'd1) == rlen_q);
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Read channel state register.
  always_ff @(posedge AXI_clk) begin
    if (rst) begin
      rstate_q  <= R_IDLE;
      rid_q     <= '0;
      ridx_q    <= '0;
      rlen_q    <= '0;
      rbeat_q   <= '0;
      rerr_q    <= 1'b0;
      rdata_q   <= '0;
      rlast_q   <= 1'b0;
      rd_bcnt_q <= '0;
    end else begin
      rstate_q  <= rstate_d;
      rid_q     <= rid_d;
      ridx_q    <= ridx_d;
      rlen_q    <= rlen_d;
      rbeat_q   <= rbeat_d;
      rerr_q    <= rerr_d;
      rdata_q   <= rdata_d;
      rlast_q   <= rlast_d;
      rd_bcnt_q <= rd_bcnt_d;
    end
  end

  assign axi.AXI_awready = awready;
  assign axi.AXI_wready  = wready;
  assign axi.AXI_bvalid  = bvalid;
  assign axi.AXI_bid     = wid_q;
  assign axi.AXI_bresp   = werr_q ? 2'b10 : 2'b00;
  assign axi.AXI_arready = arready;
  assign axi.AXI_rvalid  = rvalid;
  assign axi.AXI_rid     = rid_q;
  assign axi.AXI_rdata   = rdata_q;
  assign axi.AXI_rresp   = rerr_q ? 2'b10 : 2'b00;
  assign axi.AXI_rlast   = rlast_q;
  assign wr_bcnt         = wr_bcnt_q;
  assign rd_bcnt         = rd_bcnt_q;

endmodule

// File: tb/tb_axi3_burst_slave_mem.sv
// Randomised bench for axi3_burst_slave_mem: drivers keep a word-array model of the
// RAM and queue expected B/R responses; one negedge process compares every cycle.
module tb_axi3_burst_slave_mem;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] wr_bcnt, rd_bcnt;

  always #5 clk = ~clk;

  axi3_burst_slave_mem_if bus();

  axi3_burst_slave_mem #(.ADDR_BITS(10)) dut (
    .AXI_clk (clk),
    .rst     (rst),
    .axi     (bus),
    .wr_bcnt (wr_bcnt),
    .rd_bcnt (rd_bcnt)
  );

  typedef struct packed {
    logic [5:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rexp_t;

  typedef struct packed {
    logic [5:0] id;
    logic [1:0] resp;
  } bexp_t;

  int          vectors = 0;
  int          misses  = 0;
  logic [31:0] model_mem [DEPTH];
  rexp_t       rq[$];
  bexp_t       bq[$];
  int unsigned exp_wr = 0;
  int unsigned exp_rd = 0;
  bit          prev_rst = 1'b1;
  logic [31:0] rcap[$];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  int          wbeats_done = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      misses++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of counters, B and R channels against the queued expectations.
  always @(negedge clk) begin
    if (rst) begin
      rq.delete();
      bq.delete();
      exp_wr   = 0;
      exp_rd   = 0;
      prev_rst = 1'b1;
    end else begin
      if (prev_rst) begin
        chk("rst_rvalid",  {63'd0, bus.AXI_rvalid},  64'd0);
        chk("rst_bvalid",  {63'd0, bus.AXI_bvalid},  64'd0);
        chk("rst_wready",  {63'd0, bus.AXI_wready},  64'd0);
        chk("rst_awready", {63'd0, bus.AXI_awready}, 64'd1);
        chk("rst_arready", {63'd0, bus.AXI_arready}, 64'd1);
      end
      prev_rst = 1'b0;
      chk("wr_bcnt", {32'd0, wr_bcnt}, {32'd0, exp_wr});
      chk("rd_bcnt", {32'd0, rd_bcnt}, {32'd0, exp_rd});
      if (bus.AXI_bvalid) begin
        if (bq.size() == 0) begin
          chk("b_unexpected", {63'd0, bus.AXI_bvalid}, 64'd0);
        end else begin
          chk("bid",   {58'd0, bus.AXI_bid},   {58'd0, bq[0].id});
          chk("bresp", {62'd0, bus.AXI_bresp}, {62'd0, bq[0].resp});
          if (bus.AXI_bready) begin
            void'(bq.pop_front());
            exp_wr++;
          end
        end
      end
      if (bus.AXI_rvalid) begin
        if (rq.size() == 0) begin
          chk("r_unexpected", {63'd0, bus.AXI_rvalid}, 64'd0);
        end else begin
          chk("rid",   {58'd0, bus.AXI_rid},   {58'd0, rq[0].id});
          chk("rdata", {32'd0, bus.AXI_rdata}, {32'd0, rq[0].data});
          chk("rresp", {62'd0, bus.AXI_rresp}, {62'd0, rq[0].resp});
          chk("rlast", {63'd0, bus.AXI_rlast}, {63'd0, rq[0].last});
          if (bus.AXI_rready) begin
            if (rq[0].last) exp_rd++;
            void'(rq.pop_front());
          end
        end
      end
    end
  end

  // Write burst from wd/ws; wlast_at beyond len means wlast never asserted.
  task automatic do_write(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input int wlast_at, input bit gaps);
    bit          err_a;
    bit          err;
    logic [9:0]  idx;
    int          n;
    err_a = (size != 3'b010) || (burst != 2'b01);
    err   = err_a || (wlast_at != int'(len));
    bq.push_back('{id: id, resp: (err ? 2'b10 : 2'b00)});
    bus.AXI_awid    = id;
    bus.AXI_awaddr  = addr;
    bus.AXI_awlen   = len;
    bus.AXI_awsize  = size;
    bus.AXI_awburst = burst;
    bus.AXI_awvalid = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (rst) begin bus.AXI_awvalid = 1'b0; return; end
      if (bus.AXI_awready) break;
      n++;
      if (n > 50) begin
        chk("aw_timeout", {63'd0, bus.AXI_awready}, 64'd1);
        bus.AXI_awvalid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.AXI_awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.AXI_wvalid = 1'b0;
        @(posedge clk); #1;
      end
      bus.AXI_wid    = id;
      bus.AXI_wdata  = wd[b];
      bus.AXI_wstrb  = ws[b];
      bus.AXI_wlast  = (b == wlast_at);
      bus.AXI_wvalid = 1'b1;
      n = 0;
      while (1) begin
        @(negedge clk);
        if (rst) begin bus.AXI_wvalid = 1'b0; bus.AXI_wlast = 1'b0; return; end
        if (bus.AXI_wready) break;
        n++;
        if (n > 50) begin
          chk("w_timeout", {63'd0, bus.AXI_wready}, 64'd1);
          bus.AXI_wvalid = 1'b0;
          return;
        end
        @(posedge clk); #1;
      end
      @(posedge clk);
      if (!(err_a || (wlast_at < b))) begin
        idx = addr[11:2] + 10'(b);
        for (int l = 0; l < 4; l++)
          if (ws[b][l]) model_mem[idx][8*l +: 8] = wd[b][8*l +: 8];
      end
      wbeats_done++;
      #1;
    end
    bus.AXI_wvalid = 1'b0;
    bus.AXI_wlast  = 1'b0;
    n = 0;
    while (1) begin
      bus.AXI_bready = (gaps && n < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (rst) begin bus.AXI_bready = 1'b0; return; end
      if (bus.AXI_bvalid && bus.AXI_bready) break;
      n++;
      if (n > 100) begin
        chk("b_timeout", {63'd0, bus.AXI_bvalid}, 64'd1);
        bus.AXI_bready = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.AXI_bready = 1'b0;
  endtask

  // Read burst; accepted beat data is captured into rcap.
  task automatic do_read(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input bit stall, input bit b2b);
    bit         err;
    logic [9:0] idx;
    int         n;
    int         got;
    int         cyc;
    err = (size != 3'b010) || (burst != 2'b01);
    for (int b = 0; b <= int'(len); b++) begin
      idx = addr[11:2] + 10'(b);
      rq.push_back('{id: id, data: (err ? 32'd0 : model_mem[idx]),
                     resp: (err ? 2'b10 : 2'b00), last: (b == int'(len))});
    end
    rcap.delete();
    bus.AXI_arid    = id;
    bus.AXI_araddr  = addr;
    bus.AXI_arlen   = len;
    bus.AXI_arsize  = size;
    bus.AXI_arburst = burst;
    bus.AXI_arvalid = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (rst) begin bus.AXI_arvalid = 1'b0; return; end
      if (bus.AXI_arready) break;
      n++;
      if (n > 50) begin
        chk("ar_timeout", {63'd0, bus.AXI_arready}, 64'd1);
        bus.AXI_arvalid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.AXI_arvalid = 1'b0;
    bus.AXI_rready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    if (rst) begin bus.AXI_rready = 1'b0; return; end
    chk("r_latency", {63'd0, bus.AXI_rvalid}, 64'd1);
    got = 0;
    cyc = 0;
    while (1) begin
      if (rst) begin bus.AXI_rready = 1'b0; return; end
      cyc++;
      if (bus.AXI_rvalid && bus.AXI_rready) begin
        rcap.push_back(bus.AXI_rdata);
        got++;
      end
      if (got == int'(len) + 1) break;
      if (cyc > 200) begin
        chk("r_timeout", 64'(got), 64'(int'(len) + 1));
        bus.AXI_rready = 1'b0;
        return;
      end
      @(posedge clk); #1;
      bus.AXI_rready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.AXI_rready = 1'b0;
    if (b2b) chk("r_b2b_cycles", 64'(cyc), 64'(int'(len) + 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          wl;
    bus.AXI_awvalid = 1'b0; bus.AXI_wvalid = 1'b0; bus.AXI_bready = 1'b0;
    bus.AXI_arvalid = 1'b0; bus.AXI_rready = 1'b0; bus.AXI_wlast = 1'b0;
    bus.AXI_awid = '0; bus.AXI_awaddr = '0; bus.AXI_awlen = '0; bus.AXI_awsize = 3'b010;
    bus.AXI_awburst = 2'b01; bus.AXI_wid = '0; bus.AXI_wdata = '0; bus.AXI_wstrb = '0;
    bus.AXI_arid = '0; bus.AXI_araddr = '0; bus.AXI_arlen = '0; bus.AXI_arsize = 3'b010;
    bus.AXI_arburst = 2'b01;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Full 16-beat burst round trip.
    for (int i = 0; i < 16; i++) begin wd[i] = 32'(i); ws[i] = 4'hF; end
    do_write(6'h15, 32'h40, 4'd15, 3'b010, 2'b01, 15, 1'b0);
    do_read(6'h2A, 32'h40, 4'd15, 3'b010, 2'b01, 1'b0, 1'b1);
    chk("t1_beats", 64'(rcap.size()), 64'd16);
    for (int i = 0; i < 16 && i < rcap.size(); i++) chk("t1_data", {32'd0, rcap[i]}, 64'(i));
    @(negedge clk);
    chk("t1_wr_bcnt", {32'd0, wr_bcnt}, 64'd1);
    chk("t1_rd_bcnt", {32'd0, rd_bcnt}, 64'd1);
    @(posedge clk); #1;

    // Fill the whole RAM so every later read has a known expectation.
    for (int k = 0; k < 64; k++) begin
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      do_write(6'(k), 32'(k * 64), 4'd15, 3'b010, 2'b01, 15, 1'b0);
    end

    // Byte-lane merge.
    wd[0] = 32'hAABBCCDD; ws[0] = 4'hF;
    do_write(6'h01, 32'h0, 4'd0, 3'b010, 2'b01, 0, 1'b0);
    wd[0] = 32'h11223344; ws[0] = 4'b0101;
    do_write(6'h02, 32'h0, 4'd0, 3'b010, 2'b01, 0, 1'b0);
    do_read(6'h03, 32'h0, 4'd0, 3'b010, 2'b01, 1'b0, 1'b0);
    chk("t2_merge", {32'd0, (rcap.size() > 0) ? rcap[0] : 32'hDEAD0000}, 64'hAA22CC44);

    // Illegal burst type leaves RAM alone; illegal read size returns zero data.
    for (int i = 0; i < 4; i++) begin wd[i] = 32'h5000 + 32'(i); ws[i] = 4'hF; end
    do_write(6'h04, 32'h100, 4'd3, 3'b010, 2'b01, 3, 1'b0);
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hBAD0 + 32'(i); ws[i] = 4'hF; end
    do_write(6'h05, 32'h100, 4'd3, 3'b010, 2'b10, 3, 1'b0);
    do_read(6'h06, 32'h100, 4'd3, 3'b010, 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 4 && i < rcap.size(); i++)
      chk("t3_unchanged", {32'd0, rcap[i]}, 64'h5000 + 64'(i));
    do_read(6'h07, 32'h100, 4'd3, 3'b001, 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 4 && i < rcap.size(); i++) chk("t3_zero", {32'd0, rcap[i]}, 64'd0);

    // Stalled read.
    do_read(6'h08, 32'h200, 4'd15, 3'b010, 2'b01, 1'b1, 1'b0);

    // Wrap at the end of RAM, then an early wlast.
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
    do_write(6'h09, 32'hFFC, 4'd3, 3'b010, 2'b01, 3, 1'b0);
    do_read(6'h0A, 32'hFFC, 4'd3, 3'b010, 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 4 && i < rcap.size(); i++) chk("t5_wrap", {32'd0, rcap[i]}, 64'hA0 + 64'(i));
    do_read(6'h0B, 32'h0, 4'd0, 3'b010, 2'b01, 1'b0, 1'b0);
    chk("t5_word0", {32'd0, (rcap.size() > 0) ? rcap[0] : 32'hDEAD0000}, 64'hA1);
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(6'h0C, 32'h300, 4'd3, 3'b010, 2'b01, 1, 1'b1);
    do_read(6'h0D, 32'h300, 4'd3, 3'b010, 2'b01, 1'b0, 1'b0);

    // Reset in the middle of concurrent write and read bursts.
    for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    wbeats_done = 0;
    fork
      do_write(6'h10, 32'h400, 4'd15, 3'b010, 2'b01, 15, 1'b0);
      do_read(6'h11, 32'h600, 4'd15, 3'b010, 2'b01, 1'b0, 1'b0);
      begin
        for (int n = 0; n < 100 && wbeats_done < 5; n++) begin @(posedge clk); #2; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
      end
    join
    @(negedge clk);
    chk("t6_wr_bcnt", {32'd0, wr_bcnt}, 64'd0);
    chk("t6_rd_bcnt", {32'd0, rd_bcnt}, 64'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(6'h12, 32'h400, 4'd15, 3'b010, 2'b01, 15, 1'b0);
    do_read(6'h13, 32'h400, 4'd15, 3'b010, 2'b01, 1'b0, 1'b1);

    // Random bursts.
    for (int it = 0; it < 40; it++) begin
      addr  = $urandom;
      len   = 4'($urandom_range(0, 15));
      size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
      burst = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
      wl    = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : int'(len);
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
      do_write(6'($urandom), addr, len, size, burst, wl, 1'b1);
      if ($urandom_range(0, 1) == 0) addr = $urandom;
      len   = 4'($urandom_range(0, 15));
      size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
      burst = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
      do_read(6'($urandom), addr, len, size, burst, 1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("end_bq_empty", 64'(bq.size()), 64'd0);
    chk("end_rq_empty", 64'(rq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
